// File: rtl/video_pattern_pkg.sv
// Shared types and constants for the synthetic AXI4-Stream video pattern source.
package video_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PAT_COUNTER   = 2'd0,
    PAT_BARS      = 2'd1,
    PAT_SOLID     = 2'd2,
    PAT_SOLID_ALT = 2'd3
  } pattern_e;

  localparam logic [7:0]  PIXEL_PAD   = 8'h00;
  localparam logic [15:0] MARKER_A5A5 = 16'hA5A5;

  // White, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [23:0] BAR_TABLE [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  function automatic logic [31:0] make_pixel(input logic [23:0] rgb);
    return {PIXEL_PAD, rgb};
  endfunction

endpackage

// File: rtl/video_pattern_pixel.sv
// Combinational pattern mux: turns the beat position and latched colour into one 64-bit beat.
module video_pattern_pixel
  import video_pattern_pkg::*;
#(
  parameter int BAR_SHIFT = 5
) (
  input  pattern_e    pattern_i,
  input  logic [15:0] frame_count_i,
  input  logic [15:0] line_cnt_i,
  input  logic [15:0] beat_cnt_i,
  input  logic [23:0] color_i,
  output logic [63:0] data_o
);

  logic [2:0]  bar_idx;
  logic [31:0] pixel;

  assign bar_idx = beat_cnt_i[BAR_SHIFT+2:BAR_SHIFT];

  always_comb begin
    pixel  = make_pixel(24'h000000);
    data_o = 64'h0;
    case (pattern_i)
      PAT_COUNTER: begin
        data_o = {frame_count_i, line_cnt_i, beat_cnt_i, MARKER_A5A5};
      end
      PAT_BARS: begin
        pixel  = make_pixel(BAR_TABLE[bar_idx]);
        data_o = {pixel, pixel};
      end
      PAT_SOLID, PAT_SOLID_ALT: begin
        pixel  = make_pixel(color_i);
        data_o = {pixel, pixel};
      end
      default: begin
        data_o = 64'h0;
      end
    endcase
  end

endmodule

// File: rtl/video_pattern_source.sv
// AXI4-Stream frame generator: IDLE/ACTIVE/GAP sequencer, beat/line/frame counters and
// registered stream outputs, with data precomputed from next-state counters for full throughput.
module video_pattern_source
  import video_pattern_pkg::*;
#(
  parameter int BEATS_PER_LINE = 320,
  parameter int LINES          = 480,
  parameter int FRAME_GAP      = 16,
  parameter int BAR_SHIFT      = 5
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        aclken,
  input  logic        SW_RESET,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_color,
  output logic [63:0] m_axis_video_tdata_out,
  output logic        m_axis_video_tvalid_out,
  input  logic        m_axis_video_tready_in,
  output logic        m_axis_video_tuser_out,
  output logic        m_axis_video_tlast_out,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  if (BEATS_PER_LINE < 2 || BEATS_PER_LINE > 65535 || LINES < 1 || LINES > 65535 ||
      FRAME_GAP < 0 || FRAME_GAP > 65535 || BAR_SHIFT < 0 || BAR_SHIFT > 13) begin : g_param_check
    $error("video_pattern_source: illegal parameter value");
  end

  localparam logic [15:0] LAST_BEAT = 16'(BEATS_PER_LINE - 1);
  localparam logic [15:0] LAST_LINE = 16'(LINES - 1);
  localparam logic [15:0] LAST_GAP  = 16'(FRAME_GAP - 1);

  state_e      state_q, state_d;
  pattern_e    pattern_q, pattern_d;
  logic [23:0] color_q, color_d;
  logic [15:0] beat_cnt_q, beat_cnt_d;
  logic [15:0] line_cnt_q, line_cnt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        tvalid_q, tvalid_d;
  logic        tuser_q, tuser_d;
  logic        tlast_q, tlast_d;
  logic        frame_done_q, frame_done_d;
  logic [63:0] tdata_q, tdata_d;
  logic [63:0] pixel_data;
  logic        xfer;
  logic        start_frame;

  // aclken gating lives in the register process, so a handshake here is only tvalid & tready.
  assign xfer = tvalid_q & m_axis_video_tready_in;

  // Next-state, counter and output-flag computation.
  always_comb begin
    state_d       = state_q;
    pattern_d     = pattern_q;
    color_d       = color_q;
    beat_cnt_d    = beat_cnt_q;
    line_cnt_d    = line_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    frame_count_d = frame_count_q;
    frame_done_d  = 1'b0;
    start_frame   = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          start_frame = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (xfer) begin
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = 16'd0;
            if (line_cnt_q == LAST_LINE) begin
              line_cnt_d    = 16'd0;
              frame_done_d  = 1'b1;
              frame_count_d = frame_count_q + 16'd1;
              if (FRAME_GAP != 0) begin
                state_d   = GAP;
                gap_cnt_d = 16'd0;
              end else if (enable) begin
                start_frame = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end else begin
              line_cnt_d = line_cnt_q + 16'd1;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 16'd1;
          end
        end else begin
          state_d = ACTIVE;
        end
      end
      GAP: begin
        if (gap_cnt_q == LAST_GAP) begin
          if (enable) begin
            start_frame = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Every frame starts at line 0 beat 0 with the pattern selection re-sampled.
    if (start_frame) begin
      state_d    = ACTIVE;
      beat_cnt_d = 16'd0;
      line_cnt_d = 16'd0;
      pattern_d  = pattern_e'(pattern_sel);
      color_d    = solid_color;
    end else begin
      pattern_d = pattern_d;
    end

    tvalid_d = (state_d == ACTIVE);
    tuser_d  = tvalid_d & (line_cnt_d == 16'd0) & (beat_cnt_d == 16'd0);
    tlast_d  = tvalid_d & (beat_cnt_d == LAST_BEAT);

    if (SW_RESET) begin
      state_d       = IDLE;
      pattern_d     = PAT_COUNTER;
      color_d       = 24'h000000;
      beat_cnt_d    = 16'd0;
      line_cnt_d    = 16'd0;
      gap_cnt_d     = 16'd0;
      frame_count_d = 16'd0;
      frame_done_d  = 1'b0;
      tvalid_d      = 1'b0;
      tuser_d       = 1'b0;
      tlast_d       = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  video_pattern_pixel #(
    .BAR_SHIFT(BAR_SHIFT)
  ) u_pixel (
    .pattern_i    (pattern_d),
    .frame_count_i(frame_count_d),
    .line_cnt_i   (line_cnt_d),
    .beat_cnt_i   (beat_cnt_d),
    .color_i      (color_d),
    .data_o       (pixel_data)
  );

  assign tdata_d = tvalid_d ? pixel_data : 64'h0;

  // State registers; frame_done is forced low while aclken is low so it marks exactly one enabled edge.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q       <= IDLE;
      pattern_q     <= PAT_COUNTER;
      color_q       <= 24'h000000;
      beat_cnt_q    <= 16'd0;
      line_cnt_q    <= 16'd0;
      gap_cnt_q     <= 16'd0;
      frame_count_q <= 16'd0;
      frame_done_q  <= 1'b0;
      tvalid_q      <= 1'b0;
      tuser_q       <= 1'b0;
      tlast_q       <= 1'b0;
      tdata_q       <= 64'h0;
    end else if (aclken) begin
      state_q       <= state_d;
      pattern_q     <= pattern_d;
      color_q       <= color_d;
      beat_cnt_q    <= beat_cnt_d;
      line_cnt_q    <= line_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      frame_count_q <= frame_count_d;
      frame_done_q  <= frame_done_d;
      tvalid_q      <= tvalid_d;
      tuser_q       <= tuser_d;
      tlast_q       <= tlast_d;
      tdata_q       <= tdata_d;
    end else begin
      frame_done_q  <= 1'b0;
    end
  end

  assign m_axis_video_tdata_out  = tdata_q;
  assign m_axis_video_tvalid_out = tvalid_q;
  assign m_axis_video_tuser_out  = tuser_q;
  assign m_axis_video_tlast_out  = tlast_q;
  assign frame_done              = frame_done_q;
  assign frame_count             = frame_count_q;

endmodule

// File: tb/tb_video_pattern_source.sv
// Scoreboard bench for video_pattern_source: two instances (back-to-back frames, and gapped frames
// with colour bars); expected beats are queued when a frame is requested and popped on each transfer.
`timescale 1ns/1ps
module tb_video_pattern_source;

  localparam int A_BPL = 4, A_LINES = 2, A_GAP = 0, A_SHIFT = 5;
  localparam int B_BPL = 8, B_LINES = 2, B_GAP = 3, B_SHIFT = 0;

  typedef struct packed {
    logic        fin;
    logic        user;
    logic        last;
    logic [63:0] data;
  } beat_t;

  logic        aclk = 1'b0;
  logic        areset, aclken, SW_RESET, tready;
  logic        enable_a, enable_b;
  logic [1:0]  pattern_sel;
  logic [23:0] solid_color;
  logic [63:0] tdata_a, tdata_b;
  logic        tvalid_a, tvalid_b, tuser_a, tuser_b, tlast_a, tlast_b, done_a, done_b;
  logic [15:0] fcount_a, fcount_b;

  int          checks = 0;
  int          failures = 0;
  beat_t       q_a[$];
  beat_t       q_b[$];
  logic [23:0] bars [8];
  bit          done_exp [2];
  bit          prev_ok [2];
  logic        prev_v [2];
  logic        prev_x [2];
  logic [65:0] prev_beat [2];

  always #5 aclk = ~aclk;

  video_pattern_source #(
    .BEATS_PER_LINE(A_BPL), .LINES(A_LINES), .FRAME_GAP(A_GAP), .BAR_SHIFT(A_SHIFT)
  ) dut_a (
    .aclk(aclk), .areset(areset), .aclken(aclken), .SW_RESET(SW_RESET), .enable(enable_a),
    .pattern_sel(pattern_sel), .solid_color(solid_color),
    .m_axis_video_tdata_out(tdata_a), .m_axis_video_tvalid_out(tvalid_a),
    .m_axis_video_tready_in(tready), .m_axis_video_tuser_out(tuser_a),
    .m_axis_video_tlast_out(tlast_a), .frame_done(done_a), .frame_count(fcount_a)
  );

  video_pattern_source #(
    .BEATS_PER_LINE(B_BPL), .LINES(B_LINES), .FRAME_GAP(B_GAP), .BAR_SHIFT(B_SHIFT)
  ) dut_b (
    .aclk(aclk), .areset(areset), .aclken(aclken), .SW_RESET(SW_RESET), .enable(enable_b),
    .pattern_sel(pattern_sel), .solid_color(solid_color),
    .m_axis_video_tdata_out(tdata_b), .m_axis_video_tvalid_out(tvalid_b),
    .m_axis_video_tready_in(tready), .m_axis_video_tuser_out(tuser_b),
    .m_axis_video_tlast_out(tlast_b), .frame_done(done_b), .frame_count(fcount_b)
  );

  task automatic check_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_pix(input int pat, input int fc, input int line,
                                          input int beat, input int shift, input logic [23:0] col);
    logic [15:0] f16, l16, b16;
    logic [31:0] px;
    f16 = fc[15:0];
    l16 = line[15:0];
    b16 = beat[15:0];
    if (pat == 0) return {f16, l16, b16, 16'hA5A5};
    if (pat == 1) px = {8'h00, bars[(beat >> shift) & 7]};
    else          px = {8'h00, col};
    return {px, px};
  endfunction

  task automatic push_frame(input int s, input int pat, input int fc, input logic [23:0] col);
    int bpl, lines, shift;
    beat_t e;
    bpl   = s ? B_BPL : A_BPL;
    lines = s ? B_LINES : A_LINES;
    shift = s ? B_SHIFT : A_SHIFT;
    for (int l = 0; l < lines; l++) begin
      for (int b = 0; b < bpl; b++) begin
        e.fin  = (l == lines - 1) && (b == bpl - 1);
        e.user = (l == 0) && (b == 0);
        e.last = (b == bpl - 1);
        e.data = exp_pix(pat, fc, l, b, shift, col);
        if (s != 0) q_b.push_back(e);
        else        q_a.push_back(e);
      end
    end
  endtask

  task automatic mon(input int s, input logic v, input logic u, input logic l,
                     input logic [63:0] d, input logic done);
    beat_t e;
    logic  xfer;
    string nm;
    bit    empty;
    nm = (s != 0) ? "b" : "a";
    if (areset || SW_RESET) begin
      if (s != 0) q_b.delete();
      else        q_a.delete();
      done_exp[s] = 1'b0;
      prev_ok[s]  = 1'b0;
      return;
    end
    xfer = v && tready && aclken;
    if (done_exp[s] || done) check_eq({nm, "_frame_done"}, {65'd0, done}, {65'd0, done_exp[s]});
    done_exp[s] = 1'b0;
    // A presented but unaccepted beat must stay valid and unchanged.
    if (prev_ok[s] && prev_v[s] && !prev_x[s]) begin
      check_eq({nm, "_hold_valid"}, {65'd0, v}, 66'd1);
      check_eq({nm, "_hold_beat"}, {u, l, d}, prev_beat[s]);
    end
    if (xfer) begin
      empty = (s != 0) ? (q_b.size() == 0) : (q_a.size() == 0);
      if (empty) begin
        check_eq({nm, "_unexpected_beat"}, {u, l, d}, 66'd0);
        if ({u, l, d} == 66'd0) check_eq({nm, "_unexpected_beat"}, 66'd1, 66'd0);
      end else begin
        e = (s != 0) ? q_b.pop_front() : q_a.pop_front();
        check_eq({nm, "_tdata"}, {2'b00, d}, {2'b00, e.data});
        check_eq({nm, "_tuser_tlast"}, {64'd0, u, l}, {64'd0, e.user, e.last});
        done_exp[s] = e.fin;
      end
    end
    prev_ok[s]   = 1'b1;
    prev_v[s]    = v;
    prev_x[s]    = xfer;
    prev_beat[s] = {u, l, d};
  endtask

  always @(negedge aclk) begin
    mon(0, tvalid_a, tuser_a, tlast_a, tdata_a, done_a);
    mon(1, tvalid_b, tuser_b, tlast_b, tdata_b, done_b);
  end

  task automatic cycle();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [15:0] fc_of(input int s);
    return (s != 0) ? fcount_b : fcount_a;
  endfunction

  task automatic wait_fc(input int s, input logic [15:0] target, input bit toggle);
    logic [3:0] rdy_pat;
    int n;
    rdy_pat = 4'b1001;
    n = 0;
    while (fc_of(s) != target && n < 400) begin
      if (toggle) tready = rdy_pat[n % 4];
      cycle();
      n++;
    end
    tready = 1'b1;
    if (fc_of(s) != target) check_eq("frame_count_timeout", {50'd0, fc_of(s)}, {50'd0, target});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_a_tvalid_tuser_tlast"}, {63'd0, tvalid_a, tuser_a, tlast_a}, 66'd0);
    check_eq({tag, "_a_tdata"}, {2'b00, tdata_a}, 66'd0);
    check_eq({tag, "_a_count_done"}, {49'd0, fcount_a, done_a}, 66'd0);
    check_eq({tag, "_b_tvalid_count"}, {49'd0, fcount_b, tvalid_b}, 66'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    areset = 1'b1; aclken = 1'b1; SW_RESET = 1'b0; tready = 1'b1;
    enable_a = 1'b0; enable_b = 1'b0; pattern_sel = 2'd0; solid_color = 24'h000000;
    repeat (3) cycle();
    check_reset_outputs("reset");
    areset = 1'b0;
    cycle();

    // A: two counter frames back to back with enable held, then enable dropped mid-frame.
    push_frame(0, 0, 0, 24'h0);
    push_frame(0, 0, 1, 24'h0);
    enable_a = 1'b1;
    wait_fc(0, 16'd1, 1'b0);
    enable_a = 1'b0;
    wait_fc(0, 16'd2, 1'b0);
    repeat (3) cycle();
    check_eq("a_drain_1", {34'd0, q_a.size()}, 66'd0);
    check_eq("a_idle_after_frames", {49'd0, fcount_a, tvalid_a}, {49'd0, 16'd2, 1'b0});

    // A: solid alias under 1,0,0,1 backpressure; selection changed after start must not matter.
    pattern_sel = 2'd3; solid_color = 24'h123456;
    push_frame(0, 2, 2, 24'h123456);
    enable_a = 1'b1;
    cycle();
    enable_a = 1'b0; pattern_sel = 2'd0; solid_color = 24'hFFFFFF;
    wait_fc(0, 16'd3, 1'b1);
    repeat (2) cycle();
    check_eq("a_drain_2", {34'd0, q_a.size()}, 66'd0);

    // A: aclken low for 4 cycles mid-line freezes the stream.
    pattern_sel = 2'd0;
    push_frame(0, 0, 3, 24'h0);
    enable_a = 1'b1;
    cycle();
    enable_a = 1'b0;
    repeat (2) cycle();
    aclken = 1'b0;
    repeat (4) cycle();
    check_eq("a_clken_frozen", {49'd0, fcount_a, tvalid_a}, {49'd0, 16'd3, 1'b1});
    aclken = 1'b1;
    wait_fc(0, 16'd4, 1'b0);
    repeat (2) cycle();
    check_eq("a_drain_3", {34'd0, q_a.size()}, 66'd0);

    // A: asynchronous reset at beat 5, then a clean restart.
    push_frame(0, 0, 4, 24'h0);
    enable_a = 1'b1;
    repeat (6) cycle();
    areset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    cycle();
    areset = 1'b0;
    push_frame(0, 0, 0, 24'h0);
    cycle();
    enable_a = 1'b0;
    wait_fc(0, 16'd1, 1'b0);
    repeat (2) cycle();
    check_eq("a_drain_4", {34'd0, q_a.size()}, 66'd0);

    // B: colour bars, enable dropped at beat 2; frame completes and stream goes quiet.
    pattern_sel = 2'd1;
    push_frame(1, 1, 0, 24'h0);
    enable_b = 1'b1;
    repeat (3) cycle();
    enable_b = 1'b0;
    wait_fc(1, 16'd1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      check_eq("b_quiet_after_frame", {65'd0, tvalid_b}, 66'd0);
      cycle();
    end
    check_eq("b_drain_1", {34'd0, q_b.size()}, 66'd0);
    check_eq("b_frame_count_1", {50'd0, fcount_b}, 66'd1);

    // B: two solid frames with enable held; the inter-frame gap is exactly FRAME_GAP cycles.
    pattern_sel = 2'd2; solid_color = 24'hABCDEF;
    push_frame(1, 2, 1, 24'hABCDEF);
    push_frame(1, 2, 2, 24'hABCDEF);
    enable_b = 1'b1;
    wait_fc(1, 16'd2, 1'b0);
    n = 0;
    while (!tvalid_b && n < 20) begin
      cycle();
      n++;
    end
    check_eq("b_gap_length", n, B_GAP);
    enable_b = 1'b0;
    wait_fc(1, 16'd3, 1'b0);
    repeat (6) cycle();
    check_eq("b_drain_2", {34'd0, q_b.size()}, 66'd0);

    // B: synchronous soft reset mid-frame.
    pattern_sel = 2'd0;
    push_frame(1, 0, 3, 24'h0);
    enable_b = 1'b1;
    repeat (4) cycle();
    SW_RESET = 1'b1; enable_b = 1'b0;
    cycle();
    SW_RESET = 1'b0;
    check_eq("b_soft_reset", {1'b0, tvalid_b, fcount_b, tdata_b}, 66'd0);
    repeat (3) cycle();
    check_eq("b_soft_reset_idle", {49'd0, fcount_b, tvalid_b}, 66'd0);
    check_eq("b_drain_3", {34'd0, q_b.size()}, 66'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_pattern_source.md
Name: video_pattern_source

Overview:
- AXI4-Stream video transmitter: generates complete frames of synthetic 64-bit pixel beats with SOF on tuser and EOL on tlast.
- Feeds the Keystone input port in simulation and on hardware bring-up, replacing the camera/VDMA source.
- Supports three selectable patterns, honours downstream backpressure, reports frame completion.

Parameters:
- BEATS_PER_LINE, 320, beats per line (2 x 32-bit pixels per beat); minimum 2.
- LINES, 480, lines per frame; minimum 1.
- FRAME_GAP, 16, idle cycles (tvalid low) between frames; 0 allowed.
- BAR_SHIFT, 5, colour-bar index = beat_cnt[BAR_SHIFT+2:BAR_SHIFT].

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous reset, active-high.
- aclken  in  1  clock enable; when 0 all state and outputs hold.
- SW_RESET  in  1  synchronous soft reset; same effect as areset, sampled when aclken=1.
- enable  in  1  start/continue generating frames.
- pattern_sel  in  2  0=counter, 1=colour bars, 2=solid, 3=solid (alias).
- solid_color  in  24  RGB for solid pattern.
- m_axis_video_tdata_out  out  64  pixel beat.
- m_axis_video_tvalid_out  out  1  beat valid.
- m_axis_video_tready_in  in  1  downstream ready.
- m_axis_video_tuser_out  out  1  SOF: first beat of frame.
- m_axis_video_tlast_out  out  1  EOL: last beat of each line.
- frame_done  out  1  one-cycle pulse on transfer of a frame's final beat.
- frame_count  out  16  frames completed, wraps 0xFFFF->0.

Behaviour:
- Reset (areset or SW_RESET): state IDLE; tvalid/tuser/tlast/frame_done=0; tdata=0; beat_cnt=line_cnt=gap_cnt=frame_count=0. areset mid-frame aborts the frame immediately; the next frame restarts at line 0, beat 0 with tuser=1.
- Transfer = tvalid & tready & aclken on a rising aclk edge.
- States: IDLE, ACTIVE, GAP.
- IDLE: tvalid=0. When enable=1, latch pattern_sel and solid_color, then go to ACTIVE. The first beat is presented the next cycle, giving 1 cycle of latency from enable.
- ACTIVE: tvalid=1 continuously. On each transfer:
  - beat_cnt increments; on BEATS_PER_LINE-1 it wraps to 0 and line_cnt increments.
  - On the last beat of line LINES-1: frame_done=1 for 1 cycle, frame_count+1, then go to GAP (or to IDLE if FRAME_GAP=0 and enable=0).
  - With FRAME_GAP=0 and enable=1, the next frame starts back-to-back.
- GAP: counts FRAME_GAP cycles, then goes to IDLE if enable=0, else starts a new frame (pattern re-latched).
- enable deasserted mid-frame: the current frame completes; there is no truncation.
- Backpressure (tready=0): tdata/tuser/tlast held stable, counters frozen. tvalid is never withdrawn without a transfer, except on reset.
- tuser=1 only at line 0, beat 0. tlast=1 at beat BEATS_PER_LINE-1 of every line.
- Outputs are registered; next-beat data is computed from next counters so that there are no bubbles at full throughput (1 beat/cycle with tready=1).
- Patterns (pixel = {8'h00, R, G, B}; tdata = {pixel1, pixel0}):
  - counter: tdata = {frame_count[15:0], line_cnt[15:0], beat_cnt[15:0], 16'hA5A5}.
  - colour bars: both pixels = BAR_TABLE[beat_cnt[BAR_SHIFT+2:BAR_SHIFT]].
  - solid: both pixels = {8'h00, latched solid_color}.
- Counter widths: beat_cnt/line_cnt are 16 bits; elaboration error if BEATS_PER_LINE or LINES > 65535.
- aclken=0: no state change, no transfer, frame_done cannot pulse.

Decomposition:
- Package video_pattern_pkg: state enum (IDLE, ACTIVE, GAP); pattern_e enum; BAR_TABLE[8] of 24-bit RGB (white, yellow, cyan, green, magenta, red, blue, black); PIXEL_PAD constant 8'h00; A5A5 marker constant.
- One sub-module: video_pattern_pixel, a combinational pattern mux taking (pattern, counters, colour) and returning 64-bit data; the FSM and counters stay in the top.

Test Plan:
- BEATS_PER_LINE=4, LINES=2, FRAME_GAP=0, counter pattern, tready=1, enable held: 8 beats back-to-back. tuser only on beat 0; tlast on beats 3 and 7; beat 5 tdata = 0x0000_0001_0001_A5A5; frame_done pulse with beat 7; frame_count=1; second frame's first tdata = 0x0001_0000_0000_A5A5.
- Same config, tready toggling 1,0,0,1: tdata/tlast held unchanged across stalls; all 8 beats appear in order with no duplicates.
- Colour bars, BAR_SHIFT=0, BEATS_PER_LINE=8: beat 1 tdata = 0x00FFFF00_00FFFF00; beat 7 tdata = 0x00000000_00000000.
- enable dropped at beat 2 of an 8-beat frame, FRAME_GAP=3: frame completes; tvalid then stays 0 for at least 3 cycles; state ends in IDLE; frame_count=1.
- areset pulsed at beat 5: tvalid=0 immediately (asynchronously). After release with enable=1, the first beat has tuser=1 and line=beat=0; frame_count unchanged from reset, i.e. 0.
- aclken=0 for 4 cycles mid-line with tready=1: no beat accepted and counters held; the stream resumes seamlessly when aclken=1.
